seg7_scan_display: RTL and testbench

Scoreboard display driver: consumes the 16-bit four-hex-digit value produced by the button-driven number generator and drives a multiplexed 4-digit common-anode 7-segment display. It time-multiplexes the digits with a programmable dwell and decodes each nibble to segments. It also provides per-digit decimal points, per-digit blanking and optional leading-zero suppression. It snapshots its inputs once per scan frame so that a digit never tears mid-frame.

---
 rtl/seg7_scan_display.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//
// Drives a multiplexed 4-digit common-anode 7-segment display from a 16-bit
// four-hex-digit value. Each digit is enabled for SCAN_DIV clocks in turn.
// The inputs are snapshotted once per scan frame, at the start of the digit 0
// slot, so a digit never shows a value that changes part-way through a frame.
//
// Parameters
//   SCAN_DIV  clocks each digit is enabled (dwell), legal range 2..2^20
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   rst    in   asynchronous active-high reset
//   num    in   [15:0] four hex digits, digit i = num[4i+3:4i], digit 0 rightmost
//   dp     in   [3:0]  decimal point per digit, 1 = lit
//   blank  in   [3:0]  per-digit force-dark, 1 = digit fully off
//   lz_en  in   1 = suppress leading zeros
//   an     out  [3:0]  digit enables, active-low, an[i] drives digit i
//   seg    out  [7:0]  segments, active-low, {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_scan_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] num,
   input  logic [3:0]  dp,
   input  logic [3:0]  blank,
   input  logic        lz_en,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int             CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [1:0]    idx;
   logic [15:0]   snap_num;
   logic [3:0]    snap_dp;
   logic [3:0]    snap_blank;
   logic          snap_lz;

   logic          div_wrap;
   logic          frame_load;
   logic [3:0]    nibble;
   logic          suppress;
   logic [6:0]    digit_segs;
   logic [3:0]    an_next;
   logic [7:0]    seg_next;

   assign div_wrap   = (div_cnt == DIV_LAST);
   assign frame_load = (div_cnt == '0) && (idx == 2'd0);

   // Active-low hex decode, {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_decode(input logic [3:0] value);
      logic [6:0] segs;
      case (value)
         4'h0: segs = 7'h40;
         4'h1: segs = 7'h79;
         4'h2: segs = 7'h24;
         4'h3: segs = 7'h30;
         4'h4: segs = 7'h19;
         4'h5: segs = 7'h12;
         4'h6: segs = 7'h02;
         4'h7: segs = 7'h78;
         4'h8: segs = 7'h00;
         4'h9: segs = 7'h10;
         4'hA: segs = 7'h08;
         4'hB: segs = 7'h03;
         4'hC: segs = 7'h46;
         4'hD: segs = 7'h21;
         4'hE: segs = 7'h06;
         default: segs = 7'h0E;
      endcase
      return segs;
   endfunction

   // Prescaler and digit index.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         idx     <= 2'd0;
      end else if (div_wrap) begin
         div_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Frame snapshot: inputs are sampled only at the start of a frame.
   // Resetting snap_blank to all ones keeps the display dark until the
   // first snapshot has reached the output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_num   <= 16'h0000;
         snap_dp    <= 4'h0;
         snap_blank <= 4'hF;
         snap_lz    <= 1'b0;
      end else if (frame_load) begin
         snap_num   <= num;
         snap_dp    <= dp;
         snap_blank <= blank;
         snap_lz    <= lz_en;
      end
   end

   // Digit selection, leading-zero suppression and output formatting.
   // NOTE: every output of this block gets a default first so no path can
   // leave a value held, which would infer a latch.
   always_comb begin
      nibble     = snap_num[idx*4 +: 4];
      suppress   = 1'b0;
      an_next    = 4'b1111;
      seg_next   = 8'hFF;
      digit_segs = 7'h7F;

      // A digit is a leading zero when it and every digit to its left are
      // zero; digit 0 always shows so that a zero value is still visible.
      case (idx)
         2'd3:    suppress = snap_lz && (snap_num[15:12] == 4'h0);
         2'd2:    suppress = snap_lz && (snap_num[15:8]  == 8'h00);
         2'd1:    suppress = snap_lz && (snap_num[15:4]  == 12'h000);
         default: suppress = 1'b0;
      endcase

      if (!suppress) begin
         digit_segs = hex_decode(nibble);
      end

      if (!snap_blank[idx]) begin
         an_next      = 4'b1111;
         an_next[idx] = 1'b0;
         // A suppressed digit stays enabled so its decimal point can light.
         seg_next     = {~snap_dp[idx], digit_segs};
      end
   end

   // Registered outputs, one edge behind idx and the snapshot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= 8'hFF;
      end else begin
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
//
// Self-checking bench for seg7_scan_display with SCAN_DIV = 4. A behavioural
// model derives the expected an/seg from the count of clock edges since reset
// release; a compare process checks the DUT against it on every falling edge.
// Directed checks with hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] num = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic [3:0]  blank = 4'h0;
   logic        lz_en = 1'b0;
   logic [3:0]  an;
   logic [7:0]  seg;

   int checks = 0;
   int failures = 0;

   seg7_scan_display #(.SCAN_DIV(S)) dut (
      .clk   (clk),
      .rst   (rst),
      .num   (num),
      .dp    (dp),
      .blank (blank),
      .lz_en (lz_en),
      .an    (an),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          n_edge = 0;
   logic [15:0] m_num = 16'h0000;
   logic [3:0]  m_dp = 4'h0;
   logic [3:0]  m_blank = 4'hF;
   logic        m_lz = 1'b0;
   logic [3:0]  exp_an = 4'hF;
   logic [7:0]  exp_seg = 8'hFF;
   logic        cmp_en = 1'b0;

   // Edge n after release shows digit ((n-1)/S) mod 4 using the snapshot held
   // before that edge; edges where (n-1) is a multiple of 4*S reload it.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            n_edge  = 0;
            m_num   = 16'h0000;
            m_dp    = 4'h0;
            m_blank = 4'hF;
            m_lz    = 1'b0;
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
         end else begin
            int d;
            n_edge = n_edge + 1;
            d = ((n_edge - 1) / S) % 4;
            if (m_blank[d]) begin
               exp_an  = 4'hF;
               exp_seg = 8'hFF;
            end else begin
               exp_an = 4'hF & ~(4'h1 << d);
               if (m_lz && d != 0 && (m_num >> (4 * d)) == 16'h0000)
                  exp_seg = {~m_dp[d], 7'h7F};
               else
                  exp_seg = {~m_dp[d], dec[(m_num >> (4 * d)) & 16'hF]};
            end
            if ((n_edge - 1) % (4 * S) == 0) begin
               m_num   = num;
               m_dp    = dp;
               m_blank = blank;
               m_lz    = lz_en;
            end
         end
      end
   end

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      checks = checks + 1;
      if (act !== req) begin
         failures = failures + 1;
         $display("FAIL %s: an/seg got %h/%h expected %h/%h at %0t",
                  name, act[11:8], act[7:0], req[11:8], req[7:0], $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) check("model", {an, seg}, {exp_an, exp_seg});
      end
   end

   // Edge number for digit d of frame f, o cycles into the slot.
   function automatic int se(input int f, input int d, input int o);
      return 4 * S * f + d * S + 1 + o;
   endfunction

   // Wait (bounded) until the falling edge after edge k, then compare.
   task automatic lit(input string name, input int k, input logic [3:0] e_an, input logic [7:0] e_seg);
      int budget = 1000;
      while (n_edge < k && budget > 0) begin
         @(negedge clk);
         budget = budget - 1;
      end
      if (n_edge != k) begin
         checks = checks + 1;
         failures = failures + 1;
         $display("FAIL %s: reached edge %0d expected edge %0d", name, n_edge, k);
      end else begin
         check(name, {an, seg}, {e_an, e_seg});
      end
   endtask

   task automatic do_reset(input logic [15:0] n, input logic [3:0] d, input logic [3:0] b, input logic l);
      @(negedge clk);
      rst   = 1'b1;
      num   = n;
      dp    = d;
      blank = b;
      lz_en = l;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [15:0] value;
      logic [7:0]  s0, s1, s2, s3;
   } sweep_t;

   sweep_t sweep [4] = '{
      '{16'hFEDC, 8'hC6, 8'hA1, 8'h86, 8'h8E},
      '{16'hBA98, 8'h80, 8'h90, 8'h88, 8'h83},
      '{16'h7654, 8'h99, 8'h92, 8'h82, 8'hF8},
      '{16'h3210, 8'hC0, 8'hF9, 8'hA4, 8'hB0}
   };

   initial begin
      // Reset and bring-up, num = 1234.
      num = 16'h1234;
      repeat (2) @(negedge clk);
      check("rst_hold", {an, seg}, {4'hF, 8'hFF});
      cmp_en = 1'b1;
      rst = 1'b0;
      lit("bring_e1", 1, 4'hF, 8'hFF);
      lit("bring_d0", se(0, 0, 2), 4'hE, 8'h99);
      lit("bring_d1", se(0, 1, 2), 4'hD, 8'hB0);
      lit("bring_d2", se(0, 2, 2), 4'hB, 8'hA4);
      lit("bring_d3", se(0, 3, 2), 4'h7, 8'hF9);
      lit("bring_f1d0", se(1, 0, 2), 4'hE, 8'h99);

      // Decode sweep.
      foreach (sweep[i]) begin
         do_reset(sweep[i].value, 4'h0, 4'h0, 1'b0);
         lit("sweep_d0", se(0, 0, 1), 4'hE, sweep[i].s0);
         lit("sweep_d1", se(0, 1, 1), 4'hD, sweep[i].s1);
         lit("sweep_d2", se(0, 2, 1), 4'hB, sweep[i].s2);
         lit("sweep_d3", se(0, 3, 1), 4'h7, sweep[i].s3);
      end

      // Snapshot: change mid-frame while digit 1 is shown.
      do_reset(16'h1234, 4'h0, 4'h0, 1'b0);
      lit("snap_d1", se(0, 1, 1), 4'hD, 8'hB0);
      num = 16'h5678;
      lit("snap_old_d2", se(0, 2, 1), 4'hB, 8'hA4);
      lit("snap_old_d3", se(0, 3, 1), 4'h7, 8'hF9);
      lit("snap_new_d0", se(1, 0, 1), 4'hE, 8'h80);
      lit("snap_new_d1", se(1, 1, 1), 4'hD, 8'hF8);
      lit("snap_new_d2", se(1, 2, 1), 4'hB, 8'h82);
      lit("snap_new_d3", se(1, 3, 1), 4'h7, 8'h92);

      // Leading zeros.
      do_reset(16'h0030, 4'h0, 4'h0, 1'b1);
      lit("lz_d0", se(0, 0, 1), 4'hE, 8'hC0);
      lit("lz_d1", se(0, 1, 1), 4'hD, 8'hB0);
      lit("lz_d2", se(0, 2, 1), 4'hB, 8'hFF);
      lit("lz_d3", se(0, 3, 1), 4'h7, 8'hFF);
      do_reset(16'h0000, 4'h0, 4'h0, 1'b1);
      lit("lz0_d0", se(0, 0, 1), 4'hE, 8'hC0);
      lit("lz0_d1", se(0, 1, 1), 4'hD, 8'hFF);
      lit("lz0_d3", se(0, 3, 1), 4'h7, 8'hFF);
      do_reset(16'h0000, 4'h0, 4'h0, 1'b0);
      lit("nolz_d3", se(0, 3, 1), 4'h7, 8'hC0);

      // Blank and decimal points.
      do_reset(16'h8888, 4'b0101, 4'b0100, 1'b0);
      lit("bd_d0", se(0, 0, 1), 4'hE, 8'h00);
      lit("bd_d1", se(0, 1, 1), 4'hD, 8'h80);
      lit("bd_d2", se(0, 2, 1), 4'hF, 8'hFF);
      lit("bd_d3", se(0, 3, 1), 4'h7, 8'h80);

      // Asynchronous reset during the digit 2 slot.
      do_reset(16'h1234, 4'h0, 4'h0, 1'b0);
      lit("async_pre", se(0, 2, 1), 4'hB, 8'hA4);
      #2 rst = 1'b1;
      #1 check("async_immediate", {an, seg}, {4'hF, 8'hFF});
      @(negedge clk);
      rst = 1'b0;
      lit("async_e1", 1, 4'hF, 8'hFF);
      lit("async_e2", 2, 4'hE, 8'h99);
      lit("async_d1", se(0, 1, 1), 4'hD, 8'hB0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
